// File: rtl/bus_arbiter.sv
// Arbitrates the shared memory bus between instruction fetch and data access.
// Data has fixed priority; a watchdog terminates transactions the slave never answers.
module bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    // Instruction port
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_abort,
    output logic        i_done,
    output logic [31:0] i_rdata,
    output logic        i_err,
    output logic        i_stall,
    // Data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_done,
    output logic [31:0] d_rdata,
    output logic        d_err,
    // Memory bus
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t        state_q;
    logic          drop_q;
    logic [CW-1:0] cnt_q;
    logic          mem_valid_q, mem_we_q;
    logic [31:0]   mem_addr_q, mem_wdata_q;
    logic [3:0]    mem_wstrb_q;
    logic          i_done_q, i_err_q, d_done_q, d_err_q;
    logic [31:0]   i_rdata_q, d_rdata_q;

    logic [CW-1:0] cnt_d;
    logic          expire_d;
    logic          finish_d;
    logic          drop_now_d;

    // The watchdog fires on the edge at which the busy count would reach TIMEOUT.
    assign cnt_d      = cnt_q + 1'b1;
    assign expire_d   = (cnt_d == CW'(TIMEOUT));
    assign finish_d   = mem_ready || expire_d;
    assign drop_now_d = drop_q || i_abort;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            i_done_q    <= 1'b0;
            i_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            i_done_q <= 1'b0;
            i_err_q  <= 1'b0;
            d_done_q <= 1'b0;
            d_err_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (d_req) begin
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        mem_wstrb_q <= d_we ? d_wstrb : 4'b0000;
                        state_q     <= BUSY_D;
                    end else if (i_req && !i_abort) begin
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= i_addr;
                        mem_wstrb_q <= 4'b0000;
                        drop_q      <= 1'b0;
                        state_q     <= BUSY_I;
                    end
                end

                BUSY_I, BUSY_D: begin
                    if (finish_d) begin
                        mem_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                        if (state_q == BUSY_D) begin
                            d_done_q  <= 1'b1;
                            d_err_q   <= !mem_ready;
                            d_rdata_q <= mem_ready ? mem_rdata : 32'h0;
                        end else begin
                            // An abort seen at any point of the fetch swallows its completion.
                            drop_q <= 1'b0;
                            if (!drop_now_d) begin
                                i_done_q  <= 1'b1;
                                i_err_q   <= !mem_ready;
                                i_rdata_q <= mem_ready ? mem_rdata : 32'h0;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_d;
                        if (state_q == BUSY_I && i_abort) begin
                            drop_q <= 1'b1;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign i_done    = i_done_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign i_stall   = i_req && !i_done_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a negedge slave model answers the bus and a
// scoreboard of expected completions is checked whenever a done pulse appears.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, i_abort;
    logic [31:0] i_addr;
    logic        i_done, i_err, i_stall;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_done, d_err;
    logic [31:0] d_rdata;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_abort   (i_abort),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int i_done_cnt = 0;
    int d_done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        bit          chk_rdata;
    } exp_t;

    exp_t sb[$];

    // Slave: raises mem_ready after slave_wait busy cycles (large value = never).
    int          slave_wait  = 0;
    logic [31:0] slave_rdata = 32'h0;
    int          busy_cnt    = 0;

    always @(negedge clk) begin
        mem_rdata = slave_rdata;
        if (reset || !mem_valid) begin
            busy_cnt  = 0;
            mem_ready = 1'b0;
        end else begin
            mem_ready = (busy_cnt == slave_wait);
            busy_cnt++;
        end
    end

    // Completion monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (i_done || d_done)) begin
            if (i_done) i_done_cnt++;
            if (d_done) d_done_cnt++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("done_port_is_d", 32'(d_done), 32'(e.is_d));
                check("done_single_port", 32'(i_done && d_done), 32'd0);
                check("done_err", 32'(e.is_d ? d_err : i_err), 32'(e.err));
                if (e.chk_rdata)
                    check("done_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
            end
        end
    end

    // Waits for a done pulse, checking the bus contents every cycle mem_valid is high.
    task automatic run_txn(input bit want_d, input logic [31:0] exp_addr, input bit exp_we,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                           output int n, output int vcyc);
        bit done;
        done = 1'b0;
        n    = 0;
        vcyc = 0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
            if (mem_valid) begin
                vcyc++;
                check("bus_addr", mem_addr, exp_addr);
                check("bus_we", 32'(mem_we), 32'(exp_we));
                check("bus_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                if (exp_we) check("bus_wdata", mem_wdata, exp_wdata);
            end
            done = want_d ? d_done : i_done;
        end
        check(want_d ? "d_done_seen" : "i_done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input logic level);
        int n;
        n = 0;
        while (mem_valid !== level && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("wait_mem_valid", 32'(mem_valid), 32'(level));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, vcyc, cnt_before;

        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = 32'h0;
        i_abort = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
        d_wstrb = 4'h0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_dones", 32'({i_done, d_done, i_err, d_err}), 32'd0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_i_stall", 32'(i_stall), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single fetch, two wait states
        slave_wait  = 2;
        slave_rdata = 32'h0000_0013;
        i_req  = 1'b1;
        i_addr = 32'h8000_0000;
        sb.push_back('{is_d: 1'b0, rdata: 32'h0000_0013, err: 1'b0, chk_rdata: 1'b1});
        #1 check("fetch_stall_high", 32'(i_stall), 32'd1);
        cnt_before = i_done_cnt;
        run_txn(1'b0, 32'h8000_0000, 1'b0, 32'h0, 4'h0, n, vcyc);
        check("fetch_stall_done", 32'(i_stall), 32'd0);
        check("fetch_latency", 32'(n), 32'd4);
        check("fetch_valid_cycles", 32'(vcyc), 32'd3);
        i_req = 1'b0;
        @(negedge clk);
        check("fetch_one_done", 32'(i_done_cnt - cnt_before), 32'd1);
        check("fetch_rdata_held", i_rdata, 32'h0000_0013);

        // Contention: data write wins, fetch follows on the next IDLE cycle
        slave_wait  = 0;
        slave_rdata = 32'h0000_0093;
        i_req   = 1'b1;
        i_addr  = 32'h8000_0004;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_1000;
        d_wdata = 32'hDEAD_BEEF;
        d_wstrb = 4'hF;
        sb.push_back('{is_d: 1'b1, rdata: 32'h0, err: 1'b0, chk_rdata: 1'b0});
        sb.push_back('{is_d: 1'b0, rdata: 32'h0000_0093, err: 1'b0, chk_rdata: 1'b1});
        run_txn(1'b1, 32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, n, vcyc);
        check("wr_latency", 32'(n), 32'd2);
        check("wr_stall_held", 32'(i_stall), 32'd1);
        d_req = 1'b0;
        d_we  = 1'b0;
        run_txn(1'b0, 32'h8000_0004, 1'b0, 32'h0, 4'h0, n, vcyc);
        check("fetch_after_wr_latency", 32'(n), 32'd2);
        i_req = 1'b0;
        @(negedge clk);

        // Abort during BUSY_I: bus completes, no i_done, next fetch is normal
        slave_wait  = 2;
        slave_rdata = 32'hAAAA_5555;
        cnt_before  = i_done_cnt;
        i_req  = 1'b1;
        i_addr = 32'h8000_0008;
        wait_valid(1'b1);
        i_abort = 1'b1;
        i_req   = 1'b0;
        @(negedge clk);
        i_abort = 1'b0;
        wait_valid(1'b0);
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(i_done_cnt - cnt_before), 32'd0);
        check("abort_rdata_unchanged", i_rdata, 32'h0000_0093);
        slave_wait  = 1;
        slave_rdata = 32'h1234_5678;
        i_req  = 1'b1;
        i_addr = 32'h8000_0100;
        sb.push_back('{is_d: 1'b0, rdata: 32'h1234_5678, err: 1'b0, chk_rdata: 1'b1});
        run_txn(1'b0, 32'h8000_0100, 1'b0, 32'h0, 4'h0, n, vcyc);
        check("post_abort_latency", 32'(n), 32'd3);
        i_req = 1'b0;
        @(negedge clk);

        // Boundary: mem_ready on the expiry cycle completes normally
        slave_wait  = 3;
        slave_rdata = 32'hCAFE_F00D;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_2000;
        d_wstrb = 4'hF;
        sb.push_back('{is_d: 1'b1, rdata: 32'hCAFE_F00D, err: 1'b0, chk_rdata: 1'b1});
        run_txn(1'b1, 32'h0000_2000, 1'b0, 32'h0, 4'h0, n, vcyc);
        check("edge_latency", 32'(n), 32'd5);
        check("edge_valid_cycles", 32'(vcyc), 32'd4);
        d_req = 1'b0;
        @(negedge clk);

        // Timeout with mem_ready never asserted
        slave_wait  = 1000;
        slave_rdata = 32'h7777_7777;
        d_req  = 1'b1;
        d_addr = 32'h0000_2004;
        sb.push_back('{is_d: 1'b1, rdata: 32'h0, err: 1'b1, chk_rdata: 1'b1});
        run_txn(1'b1, 32'h0000_2004, 1'b0, 32'h0, 4'h0, n, vcyc);
        check("timeout_latency", 32'(n), 32'd5);
        check("timeout_valid_cycles", 32'(vcyc), 32'd4);
        check("timeout_bus_dropped", 32'(mem_valid), 32'd0);
        d_req = 1'b0;
        @(negedge clk);

        // Reset during BUSY_D
        cnt_before = d_done_cnt;
        d_req  = 1'b1;
        d_addr = 32'h0000_3000;
        wait_valid(1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_mem_valid", 32'(mem_valid), 32'd0);
        check("midrst_d_done", 32'(d_done), 32'd0);
        reset = 1'b0;
        d_req = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_done", 32'(d_done_cnt - cnt_before), 32'd0);
        slave_wait  = 0;
        slave_rdata = 32'h55AA_55AA;
        d_req  = 1'b1;
        d_addr = 32'h0000_3004;
        sb.push_back('{is_d: 1'b1, rdata: 32'h55AA_55AA, err: 1'b0, chk_rdata: 1'b1});
        run_txn(1'b1, 32'h0000_3004, 1'b0, 32'h0, 4'h0, n, vcyc);
        check("post_rst_latency", 32'(n), 32'd2);
        d_req = 1'b0;
        repeat (2) @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
